// File: rtl/rd_seq_pkg.sv
// Package for the read-sequencer FIFO: sequencer state encoding and the
// default values shared by the top, the ROM and the bus interface.
// Build option: define RD_SEQ_LOOP_EN to enable multi-pass loop counting.
package rd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDR_LEN_DEF = 5;
    localparam int DATA_LEN_DEF = 32;
    localparam int PE_ID_DEF    = 0;
    localparam int LOOP_W_DEF   = 8;

endpackage

// File: rtl/rd_seq_fifo_if.sv
// Control/data bus of the read-sequencer FIFO. The master side issues
// start/restart/rd and the program window; the slave side returns the
// instruction stream and its status.
interface rd_seq_fifo_if
    import rd_seq_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int LOOP_W   = LOOP_W_DEF
) ();

    logic                start;
    logic                restart;
    logic                noStall;
    logic                rd;
    logic [ADDR_LEN-1:0] startAddr;
    logic [ADDR_LEN-1:0] endAddr;
    logic [LOOP_W-1:0]   loopCnt;
    logic [DATA_LEN-1:0] dataOut;
    logic                dataValid;
    logic [ADDR_LEN-1:0] headAddr;
    logic                busy;
    logic                done;

    modport master (
        output start, restart, noStall, rd, startAddr, endAddr, loopCnt,
        input  dataOut, dataValid, headAddr, busy, done
    );

    modport slave (
        input  start, restart, noStall, rd, startAddr, endAddr, loopCnt,
        output dataOut, dataValid, headAddr, busy, done
    );

endinterface

// File: rtl/rd_seq_mem.sv
// Synchronous-read instruction ROM, 2^ADDR_LEN x DATA_LEN. The contents are
// a fixed image selected by PE_ID so every processing element sees its own
// program; the word at address a is {PE_ID[7:0], a[7:0], 16'hC0DE ^ a*273}
// truncated or zero-extended to DATA_LEN.
module rd_seq_mem
    import rd_seq_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int PE_ID    = PE_ID_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [ADDR_LEN-1:0] addr,
    output logic [DATA_LEN-1:0] q
);

    logic [DATA_LEN-1:0] data_p1;

    // Image generator: pure function of address and PE_ID, maps to a ROM.
    function automatic logic [DATA_LEN-1:0] image_word(input logic [ADDR_LEN-1:0] a);
        logic [31:0] w;
        w = ((32'(PE_ID) & 32'hFF) << 24)
          | ((32'(a) & 32'hFF) << 16)
          | ((32'hC0DE ^ (32'(a) * 32'd273)) & 32'hFFFF);
        return DATA_LEN'(w);
    endfunction

    // Registered read port: the word only changes on an enabled read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_p1 <= '0;
        end else if (en) begin
            data_p1 <= image_word(addr);
        end
    end

    assign q = data_p1;

endmodule

// File: rtl/rd_seq_fifo.sv
// Read-sequencer FIFO: walks a latched program window [startAddr..endAddr]
// of an instruction ROM, one word per accepted read, wrapping modulo the
// buffer depth. With RD_SEQ_LOOP_EN defined the window is replayed
// loopCnt+1 times and the sequencer then parks in DONE; without it the
// window repeats forever and done stays low.
module rd_seq_fifo
    import rd_seq_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int PE_ID    = PE_ID_DEF,
    parameter int LOOP_W   = LOOP_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    rd_seq_fifo_if.slave bus
);

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] head_q, head_d;
    logic [ADDR_LEN-1:0] cfg_start_q, cfg_start_d;
    logic [ADDR_LEN-1:0] cfg_end_q, cfg_end_d;
    logic                vld_p1, vld_d;
`ifdef RD_SEQ_LOOP_EN
    logic [LOOP_W-1:0]   loop_idx_q, loop_idx_d;
    logic [LOOP_W-1:0]   cfg_loop_q, cfg_loop_d;
`endif

    logic accept;
    logic restart_hit;
    logic pass_end;

    // Restart outranks everything, including a stall, but only once started.
    assign restart_hit = bus.restart && (state_q != IDLE);
    assign accept      = bus.rd && bus.noStall && (state_q == RUN) && !bus.restart;
    assign pass_end    = (head_q == cfg_end_q);

    // State, pointer, latched window and valid flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            cfg_start_q <= '0;
            cfg_end_q   <= '0;
            vld_p1      <= 1'b0;
`ifdef RD_SEQ_LOOP_EN
            loop_idx_q  <= '0;
            cfg_loop_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            cfg_start_q <= cfg_start_d;
            cfg_end_q   <= cfg_end_d;
            vld_p1      <= vld_d;
`ifdef RD_SEQ_LOOP_EN
            loop_idx_q  <= loop_idx_d;
            cfg_loop_q  <= cfg_loop_d;
`endif
        end
    end

    // Next-state logic: restart, then stall freeze, then per-state behaviour.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        cfg_start_d = cfg_start_q;
        cfg_end_d   = cfg_end_q;
        vld_d       = vld_p1;
`ifdef RD_SEQ_LOOP_EN
        loop_idx_d  = loop_idx_q;
        cfg_loop_d  = cfg_loop_q;
`endif
        if (restart_hit) begin
            state_d = RUN;
            head_d  = cfg_start_q;
            vld_d   = 1'b0;
`ifdef RD_SEQ_LOOP_EN
            loop_idx_d = '0;
`endif
        end else if (bus.noStall) begin
            // A non-stalled cycle without an accepted read drops valid.
            vld_d = accept;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d     = RUN;
                        cfg_start_d = bus.startAddr;
                        cfg_end_d   = bus.endAddr;
                        head_d      = bus.startAddr;
`ifdef RD_SEQ_LOOP_EN
                        cfg_loop_d  = bus.loopCnt;
                        loop_idx_d  = '0;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (pass_end) begin
                            head_d = cfg_start_q;
`ifdef RD_SEQ_LOOP_EN
                            if (loop_idx_q == cfg_loop_q) begin
                                state_d = DONE;
                            end else begin
                                loop_idx_d = loop_idx_q + LOOP_W'(1);
                            end
`endif
                        end else begin
                            // Natural modulo-2^ADDR_LEN wrap of the pointer.
                            head_d = head_q + ADDR_LEN'(1);
                        end
                    end
                end
                default: begin
                    // DONE: only restart or reset leave this state.
                end
            endcase
        end
    end

    rd_seq_mem #(
        .ADDR_LEN (ADDR_LEN),
        .DATA_LEN (DATA_LEN),
        .PE_ID    (PE_ID)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .addr  (head_q),
        .q     (bus.dataOut)
    );

    assign bus.dataValid = vld_p1;
    assign bus.headAddr  = head_q;
    assign bus.busy      = (state_q == RUN);
`ifdef RD_SEQ_LOOP_EN
    assign bus.done      = (state_q == DONE);
`else
    assign bus.done      = 1'b0;
`endif

endmodule

// File: tb/tb_rd_seq_fifo.sv
// Bench for rd_seq_fifo: per-cycle vector table plus hand sequences for the
// loop count and asynchronous reset, with a queue of expected ROM words.
module tb_rd_seq_fifo;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int PE = 0;
`ifdef RD_SEQ_LOOP_EN
    localparam bit L = 1'b1;
`else
    localparam bit L = 1'b0;
`endif

    typedef struct {
        bit rst, st, rs, ns, rd;
        int sa, ea, lc;
        int rd_addr;   // address whose word must appear after this cycle, -1 none
        int e_head;
        bit e_busy, e_done;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] last_word = '0;
    bit            last_valid = 1'b0;
    vec_t          tbl[$];

    rd_seq_fifo_if #(.ADDR_LEN(AW), .DATA_LEN(DW), .LOOP_W(LW)) bus ();

    rd_seq_fifo #(.ADDR_LEN(AW), .DATA_LEN(DW), .PE_ID(PE), .LOOP_W(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] exp_word(input int a);
        logic [15:0] lo;
        logic [7:0]  pe8;
        logic [7:0]  a8;
        lo  = 16'((a * 273) & 'hFFFF);
        pe8 = 8'(PE);
        a8  = 8'(a);
        return {pe8, a8, 16'hC0DE ^ lo};
    endfunction

    function automatic vec_t mk(input bit rst, st, rs, ns, rd,
                                input int sa, ea, lc, rd_addr, e_head,
                                input bit e_busy, e_done);
        vec_t v;
        v.rst = rst; v.st = st; v.rs = rs; v.ns = ns; v.rd = rd;
        v.sa = sa; v.ea = ea; v.lc = lc; v.rd_addr = rd_addr;
        v.e_head = e_head; v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".head"},  64'(bus.headAddr),  64'd0);
        chk({tag, ".valid"}, 64'(bus.dataValid), 64'd0);
        chk({tag, ".data"},  64'(bus.dataOut),   64'd0);
        chk({tag, ".busy"},  64'(bus.busy),      64'd0);
        chk({tag, ".done"},  64'(bus.done),      64'd0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        bit e_valid;
        reset         = v.rst ? 1'b0 : 1'b1;
        bus.start     = v.st;
        bus.restart   = v.rs;
        bus.noStall   = v.ns;
        bus.rd        = v.rd;
        bus.startAddr = v.sa[AW-1:0];
        bus.endAddr   = v.ea[AW-1:0];
        bus.loopCnt   = v.lc[LW-1:0];
        if (v.rd_addr >= 0) sb.push_back(exp_word(v.rd_addr));
        @(posedge clk);
        #1;
        if (v.rst) begin
            sb.delete();
            last_word = '0;
            e_valid = 1'b0;
        end else if (v.rd_addr >= 0) begin
            e_valid = 1'b1;
        end else if (!v.ns && !v.rs) begin
            e_valid = last_valid;
        end else begin
            e_valid = 1'b0;
        end
        chk({tag, ".valid"}, 64'(bus.dataValid), 64'(e_valid));
        if (v.rd_addr >= 0) begin
            if (sb.size() > 0) last_word = sb.pop_front();
        end
        chk({tag, ".data"}, 64'(bus.dataOut),  64'(last_word));
        chk({tag, ".head"}, 64'(bus.headAddr), 64'(v.e_head));
        chk({tag, ".busy"}, 64'(bus.busy),     64'(v.e_busy));
        chk({tag, ".done"}, 64'(bus.done),     64'(v.e_done));
        last_valid = e_valid;
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.restart = 1'b0; bus.noStall = 1'b1; bus.rd = 1'b0;
        bus.startAddr = '0; bus.endAddr = '0; bus.loopCnt = '0;
        #1;
        chk_zero("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Window 2..5, single pass, then read in DONE and restart with rd.
        tbl.push_back(mk(0,1,0,1,0, 2,5,0, -1, 2, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 2,5,0,  2, 3, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 2,5,0,  3, 4, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 2,5,0,  4, 5, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 2,5,0,  5, 2, !L, L));
        tbl.push_back(mk(0,0,0,1,1, 2,5,0, L ? -1 : 2, L ? 2 : 3, !L, L));
        tbl.push_back(mk(0,0,1,1,1, 2,5,0, -1, 2, 1, 0));
        // Wrapping window 30..1.
        tbl.push_back(mk(1,0,0,1,0, 0,0,0, -1, 0, 0, 0));
        tbl.push_back(mk(0,1,0,1,0, 30,1,0, -1, 30, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 30,1,0, 30, 31, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 30,1,0, 31,  0, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 30,1,0,  0,  1, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 30,1,0,  1, 30, !L, L));
        // Window 5..9: idle restart, start+restart, stall, restart cases.
        tbl.push_back(mk(1,0,0,1,0, 0,0,0, -1, 0, 0, 0));
        tbl.push_back(mk(0,0,1,1,1, 5,9,1, -1, 0, 0, 0));
        tbl.push_back(mk(0,1,1,1,0, 5,9,1, -1, 5, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 0,31,3, 5, 6, 1, 0));
        tbl.push_back(mk(0,1,0,0,1, 0,31,3, -1, 6, 1, 0));
        tbl.push_back(mk(0,1,0,0,1, 0,31,3, -1, 6, 1, 0));
        tbl.push_back(mk(0,1,0,0,1, 0,31,3, -1, 6, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 0,31,3,  6, 7, 1, 0));
        tbl.push_back(mk(0,0,1,1,1, 0,31,3, -1, 5, 1, 0));
        tbl.push_back(mk(0,0,0,1,1, 0,31,3,  5, 6, 1, 0));
        tbl.push_back(mk(0,0,1,0,1, 0,31,3, -1, 5, 1, 0));
        tbl.push_back(mk(0,0,0,1,0, 0,31,3, -1, 5, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Three passes over window 4..5.
        apply(mk(1,0,0,1,0, 0,0,0, -1, 0, 0, 0), "loop.rst");
        apply(mk(0,1,0,1,0, 4,5,2, -1, 4, 1, 0), "loop.start");
        for (int i = 0; i < 6; i++) begin
            apply(mk(0,0,0,1,1, 4,5,2, 4 + (i % 2), (i % 2) ? 4 : 5,
                     (i == 5) ? !L : 1'b1, (i == 5) ? L : 1'b0),
                  $sformatf("loop.rd%0d", i));
        end
        apply(mk(0,0,0,1,1, 4,5,2, L ? -1 : 4, L ? 4 : 5, !L, L), "loop.after");
        apply(mk(0,0,1,1,0, 4,5,2, -1, 4, 1, 0), "loop.restart");

        // Asynchronous reset in the middle of a run with rd held.
        apply(mk(1,0,0,1,0, 0,0,0, -1, 0, 0, 0), "ar.rst");
        apply(mk(0,1,0,1,0, 10,20,0, -1, 10, 1, 0), "ar.start");
        apply(mk(0,0,0,1,1, 10,20,0, 10, 11, 1, 0), "ar.rd0");
        apply(mk(0,0,0,1,1, 10,20,0, 11, 12, 1, 0), "ar.rd1");
        #3;
        reset = 1'b0;
        #1;
        chk_zero("ar.async");
        @(posedge clk);
        #1;
        chk_zero("ar.held");
        sb.delete();
        last_word = '0;
        last_valid = 1'b0;
        reset = 1'b1;
        bus.rd = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("ar.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
